// File: rtl/line_raster_pipe.sv
// Line rasterizer front end: endpoint queue feeding a Bresenham stepper that
// emits one pixel per cycle under a valid/ready handshake.
module line_raster_pipe #(
   parameter int XW    = 10,
   parameter int YW    = 9,
   parameter int CW    = 3,
   parameter int DEPTH = 4,
   parameter int LCW   = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [XW-1:0]  x0,
   input  logic [XW-1:0]  x1,
   input  logic [YW-1:0]  y0,
   input  logic [YW-1:0]  y1,
   input  logic [CW-1:0]  in_color,
   output logic           px_valid,
   input  logic           px_ready,
   output logic [XW-1:0]  px_x,
   output logic [YW-1:0]  px_y,
   output logic [CW-1:0]  px_color,
   output logic           px_last,
   output logic           busy,
   output logic [LCW-1:0] line_count
);
   // state  | meaning
   // S_IDLE | no line loaded; waiting for a queued line
   // S_RUN  | presenting the current pixel of the loaded line

   localparam int MW = (XW > YW) ? XW : YW;
   localparam int EW = MW + 2;
   localparam int PW = $clog2(DEPTH);
   localparam int EN = 2*XW + 2*YW + CW;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [EN-1:0]  r_mem [DEPTH];
   logic [PW-1:0]  r_wptr, r_rptr;
   logic [PW:0]    r_count;
   logic           w_full, w_empty, w_push, w_pop;

   logic [XW-1:0]  r_cx;
   logic [YW-1:0]  r_cy;
   logic [CW-1:0]  r_color;
   logic [MW-1:0]  r_n, r_maj, r_min;
   logic signed [EW-1:0] r_err;
   logic           r_xmaj, r_sxn, r_syn;
   logic [LCW-1:0] r_lcnt;

   logic [XW-1:0]  w_hx0, w_hx1, w_cx_step;
   logic [YW-1:0]  w_hy0, w_hy1, w_cy_step;
   logic [CW-1:0]  w_hc;
   logic [MW-1:0]  w_dx, w_dy;
   logic           w_hxmaj;
   logic signed [EW-1:0] w_e;
   logic signed [EW:0]   w_e2, w_mext;
   logic           w_minor, w_hs, w_done, w_step, w_load;

   assign w_full   = (r_count == (PW+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign in_ready = !w_full && !flush;
   assign w_push   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {x0, y0, x1, y1, in_color};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head-of-queue setup is computed combinationally so a pop can load in one edge.
   assign {w_hx0, w_hy0, w_hx1, w_hy1, w_hc} = r_mem[r_rptr];
   assign w_dx    = MW'((w_hx1 >= w_hx0) ? (w_hx1 - w_hx0) : (w_hx0 - w_hx1));
   assign w_dy    = MW'((w_hy1 >= w_hy0) ? (w_hy1 - w_hy0) : (w_hy0 - w_hy1));
   assign w_hxmaj = (w_dx >= w_dy);

   assign w_e     = r_err + $signed({2'b00, r_min});
   assign w_e2    = {w_e, 1'b0};
   assign w_mext  = $signed({3'b000, r_maj});
   assign w_minor = (w_e2 >= w_mext);

   assign w_cx_step = r_sxn ? (r_cx - XW'(1)) : (r_cx + XW'(1));
   assign w_cy_step = r_syn ? (r_cy - YW'(1)) : (r_cy + YW'(1));

   assign w_hs   = (r_state == S_RUN) && px_ready;
   assign w_done = w_hs && (r_n == '0);
   assign w_step = w_hs && (r_n != '0);
   assign w_load = !w_empty && ((r_state == S_IDLE) || w_done);
   assign w_pop  = w_load && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_RUN;
            S_RUN:   if (w_done && w_empty) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cx    <= '0;
         r_cy    <= '0;
         r_color <= '0;
         r_n     <= '0;
         r_maj   <= '0;
         r_min   <= '0;
         r_err   <= '0;
         r_xmaj  <= 1'b0;
         r_sxn   <= 1'b0;
         r_syn   <= 1'b0;
      end else if (!flush) begin
         if (w_load) begin
            r_cx    <= w_hx0;
            r_cy    <= w_hy0;
            r_color <= w_hc;
            r_n     <= w_hxmaj ? w_dx : w_dy;
            r_maj   <= w_hxmaj ? w_dx : w_dy;
            r_min   <= w_hxmaj ? w_dy : w_dx;
            r_err   <= '0;
            r_xmaj  <= w_hxmaj;
            r_sxn   <= (w_hx1 < w_hx0);
            r_syn   <= (w_hy1 < w_hy0);
         end else if (w_step) begin
            if (r_xmaj || w_minor)  r_cx <= w_cx_step;
            if (!r_xmaj || w_minor) r_cy <= w_cy_step;
            r_err <= w_minor ? (w_e - $signed({2'b00, r_maj})) : w_e;
            r_n   <= r_n - MW'(1);
         end
      end
   end

   // Aborted lines never reach w_done with flush low, so they are not counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_lcnt <= '0;
      else if (w_done && !flush) r_lcnt <= r_lcnt + LCW'(1);
   end

   assign px_valid   = (r_state == S_RUN);
   assign px_last    = px_valid && (r_n == '0);
   assign px_x       = r_cx;
   assign px_y       = r_cy;
   assign px_color   = r_color;
   assign busy       = !w_empty || (r_state == S_RUN);
   assign line_count = r_lcnt;

endmodule

// File: tb/tb_line_raster_pipe.sv
// Self-checking bench for line_raster_pipe: table of line vectors, a Bresenham
// scoreboard, and hand sequences for latency, backpressure, flush and reset.
module tb_line_raster_pipe;
   localparam int XW = 10, YW = 9, CW = 3, DEPTH = 4, LCW = 16;

   logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, px_ready = 1'b1;
   logic [XW-1:0] x0 = '0, x1 = '0;
   logic [YW-1:0] y0 = '0, y1 = '0;
   logic [CW-1:0] in_color = '0;
   logic in_ready, px_valid, px_last, busy;
   logic [XW-1:0] px_x;
   logic [YW-1:0] px_y;
   logic [CW-1:0] px_color;
   logic [LCW-1:0] line_count;

   line_raster_pipe #(.XW(XW), .YW(YW), .CW(CW), .DEPTH(DEPTH), .LCW(LCW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1), .in_color(in_color),
      .px_valid(px_valid), .px_ready(px_ready),
      .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_last(px_last),
      .busy(busy), .line_count(line_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x0, y0, x1, y1, c;
      int npix, lx, ly;
   } vec_t;

   int n_assert = 0, n_fail = 0;
   int exp_q[$];
   int log_q[$];
   int rd_idx = 0;
   int lc = 0;

   function automatic int pk(input int x, input int y, input int c, input int l);
      return (x << 16) | (y << 4) | (c << 1) | (l & 1);
   endfunction

   // Every pixel handshake (outside flush/reset) is logged for the scoreboard.
   always @(negedge clk)
      if (rst && !flush && px_valid && px_ready)
         log_q.push_back(pk(int'(px_x), int'(px_y), int'(px_color), int'(px_last)));

   task automatic chk(input string name, input longint got, input longint exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic model_push(input int ax0, input int ay0, input int ax1, input int ay1, input int ac);
      int dx, dy, sx, sy, mj, mn, err, e, cx, cy;
      bit xm;
      dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
      dy = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
      sx = (ax1 >= ax0) ? 1 : -1;
      sy = (ay1 >= ay0) ? 1 : -1;
      xm = (dx >= dy);
      mj = xm ? dx : dy;
      mn = xm ? dy : dx;
      err = 0; cx = ax0; cy = ay0;
      for (int n = mj; n >= 0; n--) begin
         exp_q.push_back(pk(cx, cy, ac, (n == 0) ? 1 : 0));
         if (n != 0) begin
            e = err + mn;
            if (xm) cx += sx; else cy += sy;
            if (2*e >= mj) begin
               if (xm) cy += sy; else cx += sx;
               err = e - mj;
            end else err = e;
         end
      end
   endtask

   task automatic send_line(input int ax0, input int ay0, input int ax1, input int ay1, input int ac);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1); in_color = CW'(ac);
      in_valid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (ok) model_push(ax0, ay0, ax1, ay1, ac);
      else chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_drain(input int max_cyc);
      int cyc;
      cyc = 0;
      while ((busy || px_valid) && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      if (busy || px_valid) chk("drain_timeout", cyc, -1);
      #1;
   endtask

   task automatic check_log();
      int got, e;
      while (rd_idx < log_q.size()) begin
         got = log_q[rd_idx];
         rd_idx++;
         if (exp_q.size() == 0) chk("extra_pixel", got, -1);
         else begin
            e = exp_q.pop_front();
            chk("pixel", got, e);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[8];
      int exp42[5];
      int base;

      vt[0] = '{0, 0, 4, 2, 5, 5, 4, 2};
      vt[1] = '{3, 7, 3, 7, 1, 1, 3, 7};
      vt[2] = '{5, 0, 2, 6, 2, 7, 2, 6};
      vt[3] = '{10, 3, 2, 1, 7, 9, 2, 1};
      vt[4] = '{0, 8, 3, 0, 3, 9, 3, 0};
      vt[5] = '{6, 6, 0, 0, 4, 7, 0, 0};
      vt[6] = '{1, 1, 1, 5, 0, 5, 1, 5};
      vt[7] = '{4, 2, 8, 6, 6, 5, 8, 6};
      exp42[0] = pk(0, 0, 5, 0); exp42[1] = pk(1, 1, 5, 0); exp42[2] = pk(2, 1, 5, 0);
      exp42[3] = pk(3, 2, 5, 0); exp42[4] = pk(4, 2, 5, 1);

      // reset values
      #2;
      chk("rst_px_valid", px_valid, 0);
      chk("rst_px_last", px_last, 0);
      chk("rst_px_xy", {px_x, px_y, px_color}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_line_count", line_count, 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_rst", in_ready, 1);

      // latency and exact pixels of (0,0)->(4,2)
      base = log_q.size();
      send_line(0, 0, 4, 2, 5);
      chk("lat_accept_edge", px_valid, 0);
      @(negedge clk);
      chk("lat_one_edge", px_valid, 0);
      @(negedge clk);
      chk("lat_two_edges", px_valid, 1);
      chk("lat_first_xy", {px_x, px_y}, 0);
      wait_drain(100);
      check_log();
      for (int i = 0; i < 5; i++)
         chk("line42_px", (base + i < log_q.size()) ? log_q[base + i] : -1, exp42[i]);
      lc++;
      chk("line42_count", line_count, lc);

      // table vectors
      for (int i = 0; i < 8; i++) begin
         base = log_q.size();
         send_line(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].c);
         wait_drain(200);
         check_log();
         lc++;
         chk("vec_npix", log_q.size() - base, vt[i].npix);
         chk("vec_last", (log_q.size() > base) ? log_q[log_q.size() - 1] : -1,
             pk(vt[i].lx, vt[i].ly, vt[i].c, 1));
         chk("vec_line_count", line_count, lc);
      end

      // backpressure: DEPTH queued + 1 loaded
      px_ready = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) send_line(k*10, 0, k*10 + 3, 1, k);
      @(negedge clk);
      chk("in_ready_full", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("stall_valid", px_valid, 1);
      chk("stall_xy", {px_x, px_y}, 0);
      chk("stall_last", px_last, 0);
      chk("stall_busy", busy, 1);
      @(posedge clk); #1 px_ready = 1'b1;
      wait_drain(200);
      check_log();
      lc += DEPTH + 1;
      chk("bp_line_count", line_count, lc);

      // back-to-back lines, no bubble
      px_ready = 1'b0;
      send_line(0, 0, 2, 0, 3);
      send_line(9, 9, 9, 8, 4);
      @(posedge clk); #1 px_ready = 1'b1;
      begin
         int run;
         run = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (px_valid) run++;
         end
         chk("no_bubble_run", run, 5);
         @(negedge clk);
         chk("no_bubble_end", px_valid, 0);
      end
      wait_drain(50);
      check_log();
      lc += 2;
      chk("b2b_line_count", line_count, lc);

      // long line with random backpressure
      base = log_q.size();
      px_ready = 1'b0;
      send_line(0, 0, 1023, 511, 6);
      for (int k = 0; k < 6000 && (busy || px_valid); k++) begin
         @(posedge clk); #1;
         px_ready = ($urandom_range(0, 3) != 0);
      end
      px_ready = 1'b1;
      wait_drain(2000);
      check_log();
      lc++;
      chk("long_npix", log_q.size() - base, 1024);
      chk("long_last", (log_q.size() > base) ? log_q[log_q.size() - 1] : -1, pk(1023, 511, 6, 1));
      chk("long_line_count", line_count, lc);

      // flush mid-line with two lines queued
      base = log_q.size();
      px_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_line(0, k, 9, k, 2);
      @(posedge clk); #1 px_ready = 1'b1;
      @(posedge clk); #1 flush = 1'b1;
      @(negedge clk);
      chk("in_ready_flush", in_ready, 0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_px_valid", px_valid, 0);
      chk("flush_busy", busy, 0);
      chk("flush_line_count", line_count, lc);
      check_log();
      chk("flush_px_emitted", log_q.size() - base, 1);
      exp_q.delete();
      send_line(2, 2, 3, 3, 1);
      wait_drain(50);
      check_log();
      lc++;
      chk("post_flush_count", line_count, lc);

      // async reset mid-line
      px_ready = 1'b1;
      send_line(0, 0, 30, 5, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #3 rst = 1'b0; #1;
      chk("arst_px_valid", px_valid, 0);
      chk("arst_px_last", px_last, 0);
      chk("arst_px_xyc", {px_x, px_y, px_color}, 0);
      chk("arst_line_count", line_count, 0);
      chk("arst_busy", busy, 0);
      check_log();
      exp_q.delete();
      lc = 0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_post_rst", in_ready, 1);
      send_line(7, 7, 7, 7, 3);
      wait_drain(50);
      check_log();
      lc++;
      chk("post_rst_count", line_count, lc);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/line_raster_pipe.md
Name: line_raster_pipe

Overview:
- Parametrised successor to the current rasterizer front end: line endpoint capture, an N-deep line queue and a Bresenham stepper in one block, with valid/ready handshakes on both sides.
- Accepts line segments from the clipper and emits one pixel per cycle toward the frame-buffer writer.
- Adds capabilities the current front end lacks: configurable widths and depth, output backpressure, back-to-back lines with no bubble, flush, and a completed-line counter.

Parameters:
- XW, 10, x coordinate width (bits)
- YW, 9, y coordinate width (bits)
- CW, 3, color width (bits)
- DEPTH, 4, line queue depth (entries, power of 2, >=2)
- LCW, 16, completed-line counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  sync: drop queue and abort current line
- in_valid  in  1  line endpoints valid
- in_ready  out  1  line queue can accept
- x0, x1  in  XW  endpoint x
- y0, y1  in  YW  endpoint y
- in_color  in  CW  line color
- px_valid  out  1  pixel valid
- px_ready  in  1  downstream accepts pixel
- px_x  out  XW  pixel x
- px_y  out  YW  pixel y
- px_color  out  CW  pixel color
- px_last  out  1  final pixel of the line (the x1,y1 endpoint)
- busy  out  1  queue non-empty or stepper active
- line_count  out  LCW  lines fully emitted, wraps modulo 2^LCW

Behaviour:
- Reset (rst low, async):
  - Queue emptied; stepper IDLE.
  - px_valid=0, px_last=0, px_x/px_y/px_color=0, line_count=0, busy=0.
  - in_ready=1 from the first cycle after rst releases.
- Input:
  - Line accepted on a clk edge with in_valid && in_ready.
  - {x0,y0,x1,y1,in_color} written to the queue.
  - in_ready = !full && !flush.
- Queue:
  - Circular, DEPTH entries, separate read/write pointers plus count.
  - Push and pop in the same cycle are legal at any non-full occupancy; count unchanged.
  - Pointers wrap modulo DEPTH.
- Stepper FSM, states IDLE and RUN:
  - IDLE: if queue non-empty, pop the head and load it; go to RUN.
  - Load computes:
    - dx=|x1-x0|, dy=|y1-y0|, sx=(x1>=x0)?+1:-1, sy=(y1>=y0)?+1:-1.
    - Major axis is x if dx>=dy, else y. M=max(dx,dy), m=min(dx,dy).
    - Remaining count n=M. err=0, signed, width max(XW,YW)+2.
    - Current point = (x0,y0).
  - RUN: px_valid=1 showing the current point; px_last=(n==0). Outputs hold while px_valid && !px_ready.
  - On handshake with n!=0:
    - Major coordinate += its sign.
    - e=err+m. If 2e>=M, the minor coordinate += its sign and err=e-M; else err=e.
    - n -= 1.
  - On handshake with px_last:
    - line_count += 1.
    - If the queue is non-empty, pop and load the next line in the same edge and stay in RUN (no bubble cycle); else go to IDLE with px_valid=0.
- Latency:
  - Accept at edge T with an empty queue and IDLE stepper: the entry is visible after T, loaded at T+1, and px_valid is high after T+1 (2 edges).
  - Sustained throughput is 1 pixel/cycle while px_ready=1, across line boundaries.
- Degenerate line (x0==x1 && y0==y1): exactly one pixel, px_last=1.
- Endpoints are always emitted exactly; pixel count is M+1.
- flush (sync, highest priority):
  - Next edge: queue cleared, stepper to IDLE, px_valid=0.
  - An aborted line does not increment line_count.
  - A handshake in the flush cycle is discarded.
- busy = (count!=0) || (state==RUN).
- Arithmetic: all coordinate math is unsigned, with wrap-free operation guaranteed by in-range inputs; abs and compare are computed at load in a single cycle.

Test Plan:
- (0,0)->(4,2), color 5, px_ready=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2), px_last only on (4,2); first px_valid 2 edges after accept; line_count=1.
- (3,7)->(3,7) -> single pixel (3,7), px_last=1; then (5,0)->(2,6) steep negative-x line -> 7 pixels, y stepping 0..6, ending at (2,6).
- Push DEPTH+1 lines with px_ready=0 -> in_ready drops after DEPTH+1 accepted (DEPTH queued + 1 loaded); px_x/px_y stable while stalled.
- Two queued lines (0,0)->(2,0) and (9,9)->(9,8), px_ready=1 -> 5 consecutive px_valid cycles with no gap; line_count=2 at end.
- Random px_ready toggling on (0,0)->(1023,511) -> 1024 pixels, last is (1023,511), every output equals the golden Bresenham model.
- flush mid-line with 2 queued lines -> px_valid=0 next cycle, busy=0, line_count unchanged. Async rst mid-line -> all outputs 0 immediately; in_ready=1 after release.
